// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the SRAM arbiter and its pad block.
package sram_arb_pkg;

  localparam int DEF_ADDR_W       = 20;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_DISP_MAX_RUN = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACC1,
    ACC2
  } state_t;

  typedef enum logic {
    OWN_BG,
    OWN_DISP
  } owner_t;

endpackage

// File: rtl/sram_pad.sv
// SRAM pin block: registered strobes, address and write data, the dq
// output enable with its tristate, and per-port registered read capture.
module sram_pad
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              start_we,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_wdata,
  input  logic              finish,
  input  logic              cap_bg,
  input  logic              cap_disp,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              lb_n,
  output logic              ub_n,
  output logic [DATA_W-1:0] bg_rdata,
  output logic [DATA_W-1:0] disp_rdata,
  inout  wire  [DATA_W-1:0] sram_dq
);

  logic              dq_oe;
  logic [DATA_W-1:0] dout;

  assign sram_dq = dq_oe ? dout : 'z;

  // Strobes and address go active on the accept edge and drop after ACC2.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_n      <= 1'b1;
      oe_n      <= 1'b1;
      we_n      <= 1'b1;
      lb_n      <= 1'b1;
      ub_n      <= 1'b1;
      sram_addr <= '0;
      dq_oe     <= 1'b0;
    end else if (start) begin
      ce_n      <= 1'b0;
      oe_n      <= start_we;
      we_n      <= ~start_we;
      lb_n      <= 1'b0;
      ub_n      <= 1'b0;
      sram_addr <= start_addr;
      dq_oe     <= start_we;
    end else if (finish) begin
      ce_n      <= 1'b1;
      oe_n      <= 1'b1;
      we_n      <= 1'b1;
      lb_n      <= 1'b1;
      ub_n      <= 1'b1;
      dq_oe     <= 1'b0;
    end
  end

  // Write data only matters while dq_oe is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (start) dout <= start_wdata;
  end

  // Read data is sampled at the end of ACC2 into the owning port's register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bg_rdata   <= '0;
      disp_rdata <= '0;
    end else begin
      if (cap_bg)   bg_rdata   <= sram_dq;
      if (cap_disp) disp_rdata <= sram_dq;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: display has priority, the background port is
// guaranteed a slot after DISP_MAX_RUN consecutive display grants.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DISP_MAX_RUN = DEF_DISP_MAX_RUN
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bg_req,
  input  logic              i_bg_we,
  input  logic [ADDR_W-1:0] i_bg_addr,
  input  logic [DATA_W-1:0] i_bg_wdata,
  output logic              o_bg_ack,
  output logic              o_bg_rvalid,
  output logic [DATA_W-1:0] o_bg_rdata,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_ack,
  output logic              o_disp_rvalid,
  output logic [DATA_W-1:0] o_disp_rdata,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n,
  inout  wire  [DATA_W-1:0] sram_dq
);

  localparam int RUN_W = $clog2(DISP_MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(DISP_MAX_RUN);

  state_t           state;
  owner_t           owner;
  logic             acc_we;
  logic [RUN_W-1:0] run_cnt;
  logic             grant_bg;
  logic             grant_disp;
  logic             accept;
  logic             in_acc2;

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    return (v == RUN_LIMIT) ? v : v + 1'b1;
  endfunction

  // Arbitration: display first, unless the background port has waited a full run.
  always_comb begin
    grant_disp = 1'b0;
    grant_bg   = 1'b0;
    if (state == IDLE && !i_rst) begin
      grant_disp = i_disp_req && !(i_bg_req && run_cnt == RUN_LIMIT);
      grant_bg   = i_bg_req && !grant_disp;
    end
  end

  assign accept     = grant_bg | grant_disp;
  assign in_acc2    = (state == ACC2);
  assign o_bg_ack   = grant_bg;
  assign o_disp_ack = grant_disp;

  // Access sequencer: IDLE -> ACC1 -> ACC2, read-valid issued as ACC2 ends.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      owner         <= OWN_BG;
      acc_we        <= 1'b0;
      o_bg_rvalid   <= 1'b0;
      o_disp_rvalid <= 1'b0;
    end else begin
      o_bg_rvalid   <= 1'b0;
      o_disp_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= ACC1;
            owner  <= grant_disp ? OWN_DISP : OWN_BG;
            acc_we <= grant_bg && i_bg_we;
          end
        end
        ACC1: state <= ACC2;
        ACC2: begin
          state         <= IDLE;
          o_bg_rvalid   <= !acc_we && owner == OWN_BG;
          o_disp_rvalid <= !acc_we && owner == OWN_DISP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Run counter: counts display grants that made a waiting background port wait.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_cnt <= '0;
    end else if (grant_bg) begin
      run_cnt <= '0;
    end else if (grant_disp) begin
      run_cnt <= i_bg_req ? sat_inc(run_cnt) : '0;
    end
  end

  sram_pad #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_pad (
    .clk        (i_clk),
    .rst        (i_rst),
    .start      (accept),
    .start_we   (grant_bg && i_bg_we),
    .start_addr (grant_disp ? i_disp_addr : i_bg_addr),
    .start_wdata(i_bg_wdata),
    .finish     (in_acc2),
    .cap_bg     (in_acc2 && !acc_we && owner == OWN_BG),
    .cap_disp   (in_acc2 && !acc_we && owner == OWN_DISP),
    .sram_addr  (o_sram_addr),
    .ce_n       (o_sram_ce_n),
    .oe_n       (o_sram_oe_n),
    .we_n       (o_sram_we_n),
    .lb_n       (o_sram_lb_n),
    .ub_n       (o_sram_ub_n),
    .bg_rdata   (o_bg_rdata),
    .disp_rdata (o_disp_rdata),
    .sram_dq    (sram_dq)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: board SRAM model, directed transaction table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int RUN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          bg_req, bg_we, disp_req;
  logic [AW-1:0] bg_addr, disp_addr, sram_addr;
  logic [DW-1:0] bg_wdata, bg_rdata, disp_rdata;
  logic          bg_ack, bg_rvalid, disp_ack, disp_rvalid;
  logic          ce_n, oe_n, we_n, lb_n, ub_n;
  wire  [DW-1:0] sram_dq;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ref_mem [0:255];
  logic          load_init, load_pat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // SRAM model: drives dq on reads, stores on the clock edge while we_n is low.
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 'z;

  always @(posedge clk) begin
    if (load_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 16'h0101) ^ 16'hC3A5;
    end else if (load_pat) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h5A5A ^ 16'(i);
    end else if (!ce_n && !we_n) begin
      mem[sram_addr[7:0]] <= sram_dq;
    end
  end

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DISP_MAX_RUN(RUN)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_bg_req(bg_req), .i_bg_we(bg_we), .i_bg_addr(bg_addr), .i_bg_wdata(bg_wdata),
    .o_bg_ack(bg_ack), .o_bg_rvalid(bg_rvalid), .o_bg_rdata(bg_rdata),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_ack(disp_ack), .o_disp_rvalid(disp_rvalid), .o_disp_rdata(disp_rdata),
    .o_sram_addr(sram_addr), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n), .sram_dq(sram_dq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1;
    rst = 1'b1; bg_req = 1'b0; disp_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic xfer(input bit disp, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic [DW-1:0] rd, output int lat, output int wrong,
                      output logic [AW-1:0] seen_addr, output bit ok);
    @(posedge clk); #1;
    if (disp) begin
      disp_req = 1'b1; disp_addr = a;
    end else begin
      bg_req = 1'b1; bg_we = we; bg_addr = a; bg_wdata = d;
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (disp ? disp_ack : bg_ack) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    disp_req = 1'b0; bg_req = 1'b0;
    rd = '0; lat = 0; wrong = 0; seen_addr = '0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) seen_addr = sram_addr;
      if ((disp ? disp_rvalid : bg_rvalid) && lat == 0) begin
        lat = i;
        rd  = disp ? disp_rdata : bg_rdata;
      end
      if (disp ? bg_rvalid : disp_rvalid) wrong++;
    end
  endtask

  // Simultaneous-request bookkeeping: owners of outstanding reads, in order.
  bit own_q[$];

  task automatic sim_rv();
    bit o;
    if (bg_rvalid || disp_rvalid) begin
      chk("sim_rvalid_single", 32'(bg_rvalid & disp_rvalid), 0);
      if (own_q.size() == 0) begin
        chk("sim_rvalid_unexpected", 32'(1), 0);
      end else begin
        o = own_q.pop_front();
        chk("sim_rvalid_port", 32'(disp_rvalid), 32'(o));
        chk("sim_rdata", 32'(o ? disp_rdata : bg_rdata), 32'(o ? mem[8'h30] : mem[8'h20]));
      end
    end
  endtask

  typedef struct {
    bit            disp;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  vec_t          vt [6];
  logic [DW-1:0] rd;
  logic [AW-1:0] sa;
  int            lat, wrong, ngr, na, nr, nd, dcount, bg_acks, acc_hits, d_rv;
  bit            ok, got, bgraised;
  bit            order [10];
  int            ack_cyc [8];
  logic [DW-1:0] rv [8];
  // reference-model state for the randomized run
  int            since, runs;
  bit            l_disp, l_we, g_b, g_d, bg_taken, d_taken, exp_bgv, exp_dv;
  logic [DW-1:0] l_data, m_bg_rd, m_d_rd;
  logic [AW-1:0] ga;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 0, 20'h00010, 16'h0000, 16'hBEEF, 3};
    vt[1] = '{1, 0, 20'h00010, 16'h0000, 16'hBEEF, 3};
    vt[2] = '{0, 1, 20'h000A5, 16'h1234, 16'h0000, 0};
    vt[3] = '{1, 0, 20'h000A5, 16'h0000, 16'h1234, 3};
    vt[4] = '{0, 1, 20'hFFF33, 16'h8001, 16'h0000, 0};
    vt[5] = '{0, 0, 20'hFFF33, 16'h0000, 16'h8001, 3};

    // reset state, with both requests high to show acks are held off
    rst = 1'b1; load_init = 1'b1; load_pat = 1'b0;
    bg_req = 1'b1; bg_we = 1'b0; bg_addr = 20'h00055; bg_wdata = '0;
    disp_req = 1'b1; disp_addr = 20'h00066;
    @(posedge clk); #1;
    load_init = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_acks", 32'({bg_ack, disp_ack}), 0);
    chk("rst_rvalids", 32'({bg_rvalid, disp_rvalid}), 0);
    chk("rst_rdata", 32'({bg_rdata, disp_rdata}), 0);
    chk("rst_dq_released", 32'(dut.u_pad.dq_oe), 0);
    @(posedge clk); #1;
    bg_req = 1'b0; disp_req = 1'b0; rst = 1'b0;

    // single background write: timing of strobes and dq
    @(posedge clk); #1;
    bg_req = 1'b1; bg_we = 1'b1; bg_addr = 20'h00010; bg_wdata = 16'hBEEF;
    @(negedge clk);
    chk("wr_ack", 32'(bg_ack), 1);
    @(posedge clk); #1;
    bg_req = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("wr_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'b01000);
      chk("wr_dq_driven", 32'(dut.u_pad.dq_oe), 1);
      chk("wr_dq", 32'(sram_dq), 32'hBEEF);
      chk("wr_addr", 32'(sram_addr), 32'h00010);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("wr_dq_released", 32'(dut.u_pad.dq_oe), 0);
    chk("wr_ce_off", 32'(ce_n), 1);
    chk("wr_no_rvalid", 32'({bg_rvalid, disp_rvalid}), 0);

    // transaction table
    for (int k = 0; k < 6; k++) begin
      xfer(vt[k].disp, vt[k].we, vt[k].addr, vt[k].wdata, rd, lat, wrong, sa, ok);
      chk($sformatf("vec%0d_ack", k), 32'(ok), 1);
      chk($sformatf("vec%0d_addr", k), 32'(sa), 32'(vt[k].addr));
      chk($sformatf("vec%0d_latency", k), lat, vt[k].exp_lat);
      chk($sformatf("vec%0d_wrong_port", k), wrong, 0);
      if (!vt[k].we) chk($sformatf("vec%0d_rdata", k), 32'(rd), 32'(vt[k].exp_rdata));
    end

    // simultaneous requests held high: DISP x4, BG, DISP x4, BG
    rst_pulse();
    own_q.delete();
    ngr = 0;
    bg_req = 1'b1; bg_we = 1'b0; bg_addr = 20'h00020;
    disp_req = 1'b1; disp_addr = 20'h00030;
    for (int c = 0; c < 60 && ngr < 10; c++) begin
      @(negedge clk);
      sim_rv();
      chk("sim_one_ack", 32'(bg_ack & disp_ack), 0);
      if (disp_ack) begin order[ngr] = 1'b1; ngr++; own_q.push_back(1'b1); end
      else if (bg_ack) begin order[ngr] = 1'b0; ngr++; own_q.push_back(1'b0); end
      @(posedge clk); #1;
    end
    bg_req = 1'b0; disp_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      sim_rv();
    end
    chk("sim_grant_count", ngr, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("sim_order%0d", i), 32'(order[i]), 32'((i % 5) != 4));
    chk("sim_all_rvalids", own_q.size(), 0);

    // back-to-back display reads of 0..7
    @(posedge clk); #1;
    load_pat = 1'b1;
    @(posedge clk); #1;
    load_pat = 1'b0;
    disp_req = 1'b1; disp_addr = '0;
    na = 0; nr = 0;
    for (int c = 0; c < 60 && nr < 8; c++) begin
      @(negedge clk);
      if (disp_rvalid && nr < 8) begin rv[nr] = disp_rdata; nr++; end
      if (disp_ack && na < 8) begin ack_cyc[na] = c; na++; end
      @(posedge clk); #1;
      if (na == 8) disp_req = 1'b0;
      else disp_addr = AW'(na);
    end
    disp_req = 1'b0;
    chk("b2b_reads", nr, 8);
    for (int i = 1; i < 8; i++) chk($sformatf("b2b_ack_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
    for (int i = 0; i < 8; i++) chk($sformatf("b2b_rdata%0d", i), 32'(rv[i]), 32'(16'h5A5A ^ 16'(i)));

    // reset during ACC1 of a background write
    @(posedge clk); #1;
    bg_req = 1'b1; bg_we = 1'b1; bg_addr = 20'h00040; bg_wdata = 16'h7777;
    @(negedge clk);
    chk("rstmid_ack", 32'(bg_ack), 1);
    @(posedge clk); #1;
    bg_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
    chk("rstmid_dq_released", 32'(dut.u_pad.dq_oe), 0);
    d_rv = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bg_rvalid || disp_rvalid) d_rv++;
    end
    chk("rstmid_no_rvalid", d_rv, 0);
    xfer(1'b0, 1'b0, 20'h00040, 16'h0000, rd, lat, wrong, sa, ok);
    chk("rstmid_recover_ack", 32'(ok), 1);
    chk("rstmid_recover_lat", lat, 3);
    chk("rstmid_recover_rdata", 32'(rd), 32'h7777);

    // background request dropped before ack while display is busy
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = 20'h00050;
    @(negedge clk);
    chk("drop_disp_ack", 32'(disp_ack), 1);
    @(posedge clk); #1;
    disp_req = 1'b0;
    bg_req = 1'b1; bg_we = 1'b1; bg_addr = 20'h00066; bg_wdata = 16'hDEAD;
    bg_acks = 0; acc_hits = 0; d_rv = 0;
    @(negedge clk);
    if (bg_ack) bg_acks++;
    @(posedge clk); #1;
    bg_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bg_ack) bg_acks++;
      if (!ce_n && sram_addr == 20'h00066) acc_hits++;
      if (disp_rvalid) d_rv++;
    end
    chk("drop_bg_acks", bg_acks, 0);
    chk("drop_bg_access", acc_hits, 0);
    chk("drop_disp_rvalid", d_rv, 1);

    // display-only traffic, then a background request: waits exactly 4 grants
    disp_req = 1'b1; disp_addr = 20'h00001; bg_req = 1'b0;
    nd = 0; dcount = 0; got = 1'b0; bgraised = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      @(negedge clk);
      if (bg_ack) got = 1'b1;
      if (disp_ack) begin nd++; if (bgraised) dcount++; end
      @(posedge clk); #1;
      if (nd == 6 && !bgraised) begin
        bg_req = 1'b1; bg_we = 1'b0; bg_addr = 20'h00002; bgraised = 1'b1;
      end
      if (got) begin bg_req = 1'b0; disp_req = 1'b0; end
    end
    bg_req = 1'b0; disp_req = 1'b0;
    chk("dsp_only_bg_granted", 32'(got), 1);
    chk("dsp_only_run_len", dcount, RUN);
    repeat (4) @(posedge clk);

    // randomized traffic against the reference model
    rst_pulse();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    since = 4; runs = 0; l_disp = 1'b0; l_we = 1'b1; l_data = '0;
    m_bg_rd = '0; m_d_rd = '0; bg_taken = 1'b1; d_taken = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      if (bg_taken || !bg_req) begin
        bg_req = ($urandom_range(0, 3) != 0); bg_we = 1'($urandom);
        bg_addr = AW'($urandom); bg_wdata = DW'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        bg_req = 1'b0;
      end
      if (d_taken || !disp_req) begin
        disp_req = ($urandom_range(0, 2) != 0); disp_addr = AW'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        disp_req = 1'b0;
      end
      @(negedge clk);
      exp_bgv = (since == 3) && !l_disp && !l_we;
      exp_dv  = (since == 3) && l_disp && !l_we;
      if (exp_bgv) m_bg_rd = l_data;
      if (exp_dv)  m_d_rd  = l_data;
      g_d = (since >= 3) && disp_req && !(bg_req && runs == RUN);
      g_b = (since >= 3) && bg_req && !g_d;
      chk("rnd_bg_ack", 32'(bg_ack), 32'(g_b));
      chk("rnd_disp_ack", 32'(disp_ack), 32'(g_d));
      chk("rnd_bg_rvalid", 32'(bg_rvalid), 32'(exp_bgv));
      chk("rnd_disp_rvalid", 32'(disp_rvalid), 32'(exp_dv));
      chk("rnd_bg_rdata", 32'(bg_rdata), 32'(m_bg_rd));
      chk("rnd_disp_rdata", 32'(disp_rdata), 32'(m_d_rd));
      chk("rnd_ce_n", 32'(ce_n), 32'(!(since == 1 || since == 2)));
      if (g_d) runs = bg_req ? ((runs < RUN) ? runs + 1 : RUN) : 0;
      if (g_b) runs = 0;
      if (g_d || g_b) begin
        since  = 1;
        l_disp = g_d;
        l_we   = g_b && bg_we;
        ga     = g_d ? disp_addr : bg_addr;
        if (l_we) ref_mem[ga[7:0]] = bg_wdata;
        l_data = ref_mem[ga[7:0]];
      end else if (since < 4) begin
        since++;
      end
      bg_taken = g_b;
      d_taken  = g_d;
    end
    bg_req = 1'b0; disp_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
